// File: rtl/keypoint_stream_reader.sv
// Drains keypoint bank 1 then bank 2 through registered-read SRAM ports and
// streams {row,col} with layer tag and last flag over a valid/ready interface.
module keypoint_stream_reader #(
    parameter int ADDR_W     = 11,
    parameter int DEPTH      = 2048,
    parameter int ROW_W      = 9,
    parameter int COL_W      = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W:0]          kp1_count,
    input  logic [ADDR_W:0]          kp2_count,
    output logic                     kp1_rd_en,
    output logic [ADDR_W-1:0]        kp1_rd_addr,
    input  logic [ROW_W+COL_W-1:0]   kp1_rd_dout,
    output logic                     kp2_rd_en,
    output logic [ADDR_W-1:0]        kp2_rd_addr,
    input  logic [ROW_W+COL_W-1:0]   kp2_rd_dout,
    output logic                     kp_valid,
    input  logic                     kp_ready,
    output logic [ROW_W-1:0]         kp_row,
    output logic [COL_W-1:0]         kp_col,
    output logic                     kp_layer,
    output logic                     kp_last,
    output logic                     busy,
    output logic                     done
);
    localparam int WORD_W = ROW_W + COL_W;
    localparam int ENT_W  = WORD_W + 2;
    localparam int PTR_W  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [OCC_W-1:0]  OCC_LIM  = OCC_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    typedef enum logic [2:0] {IDLE, RD1, RD2, DRAIN, FIN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W:0]    c1_q, c1_d, c2_q, c2_d, lim1, lim2;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               infl_q, infl_d, infl_layer_q, infl_layer_d, infl_last_q, infl_last_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   used_q, used_d, occ;
    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];
    logic [ENT_W-1:0]   head, push_word;
    logic               pop, room, issue, at_end;

    always_comb begin
        lim1 = (kp1_count > CNT_MAX) ? CNT_MAX : kp1_count;
        lim2 = (kp2_count > CNT_MAX) ? CNT_MAX : kp2_count;
        pop  = (used_q != '0) && kp_ready;
        // Occupancy after this edge: the current pop leaves, the in-flight read lands.
        occ  = used_q - {{(OCC_W-1){1'b0}}, pop} + {{(OCC_W-1){1'b0}}, infl_q};
        room = occ < OCC_LIM;
        issue  = room && ((state_q == RD1) || (state_q == RD2));
        at_end = (state_q == RD1) ? ({1'b0, addr_q} == c1_q - CNT_ONE)
                                  : ({1'b0, addr_q} == c2_q - CNT_ONE);

        state_d      = state_q;
        c1_d         = c1_q;
        c2_d         = c2_q;
        addr_d       = addr_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        infl_d       = 1'b0;
        infl_layer_d = infl_layer_q;
        infl_last_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    c1_d    = lim1;
                    c2_d    = lim2;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    state_d = (lim1 != '0) ? RD1 : ((lim2 != '0) ? RD2 : FIN);
                end
            end
            RD1, RD2: begin
                if (issue) begin
                    infl_d       = 1'b1;
                    infl_layer_d = (state_q == RD2);
                    addr_d       = addr_q + ADDR_ONE;
                    if (at_end) begin
                        addr_d      = '0;
                        infl_last_d = (state_q == RD2) || (c2_q == '0);
                        state_d     = ((state_q == RD1) && (c2_q != '0)) ? RD2 : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (occ == '0) state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        push_word = {infl_last_q, infl_layer_q, infl_layer_q ? kp2_rd_dout : kp1_rd_dout};
        wr_ptr_d  = infl_q ? ((wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = pop ? ((rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE) : rd_ptr_q;
        used_d    = occ;
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
        always_comb begin
            mem_d[gi] = (infl_q && (wr_ptr_q == PTR_W'(gi))) ? push_word : mem_q[gi];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) mem_q[gi] <= '0;
            else        mem_q[gi] <= mem_d[gi];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            c1_q         <= '0;
            c2_q         <= '0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            infl_q       <= 1'b0;
            infl_layer_q <= 1'b0;
            infl_last_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            used_q       <= '0;
        end else begin
            state_q      <= state_d;
            c1_q         <= c1_d;
            c2_q         <= c2_d;
            addr_q       <= addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            infl_q       <= infl_d;
            infl_layer_q <= infl_layer_d;
            infl_last_q  <= infl_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            used_q       <= used_d;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign kp_valid    = (used_q != '0);
    assign kp_col      = head[COL_W-1:0];
    assign kp_row      = head[WORD_W-1:COL_W];
    assign kp_layer    = head[WORD_W];
    assign kp_last     = head[WORD_W+1];
    assign kp1_rd_en   = issue && (state_q == RD1);
    assign kp2_rd_en   = issue && (state_q == RD2);
    assign kp1_rd_addr = (state_q == RD1) ? addr_q : '0;
    assign kp2_rd_addr = (state_q == RD2) ? addr_q : '0;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_keypoint_stream_reader.sv
// Bench for keypoint_stream_reader: table of drains against a queue-based
// reference model, plus hand sequences for field packing and mid-drain reset.
module tb_keypoint_stream_reader;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;
    localparam int FDEPTH = 2;

    typedef struct packed {
        logic [8:0] row;
        logic [9:0] col;
        logic       layer;
        logic       last;
    } kp_t;

    typedef struct {
        int c1;
        int c2;
        int mode;     // 0: ready high, 1: ready 1,0,0,1, 2: random ready
        int exp_n;
        int restart;  // cycle at which a second start is pulsed, -1 for none
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   kp1_count = '0;
    logic [ADDR_W:0]   kp2_count = '0;
    logic              kp1_rd_en, kp2_rd_en;
    logic [ADDR_W-1:0] kp1_rd_addr, kp2_rd_addr;
    logic [18:0]       kp1_dout, kp2_dout;
    logic              kp_valid, kp_layer, kp_last, busy, done;
    logic              kp_ready = 1'b0;
    logic [8:0]        kp_row;
    logic [9:0]        kp_col;

    logic [18:0] mem1 [DEPTH];
    logic [18:0] mem2 [DEPTH];
    int rdcnt1 [DEPTH];
    int rdcnt2 [DEPTH];
    int total = 0;
    int bad = 0;
    vec_t vecs [7];

    always #5 clk = ~clk;

    keypoint_stream_reader #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ROW_W(9), .COL_W(10), .FIFO_DEPTH(FDEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .kp1_count(kp1_count), .kp2_count(kp2_count),
        .kp1_rd_en(kp1_rd_en), .kp1_rd_addr(kp1_rd_addr), .kp1_rd_dout(kp1_dout),
        .kp2_rd_en(kp2_rd_en), .kp2_rd_addr(kp2_rd_addr), .kp2_rd_dout(kp2_dout),
        .kp_valid(kp_valid), .kp_ready(kp_ready),
        .kp_row(kp_row), .kp_col(kp_col), .kp_layer(kp_layer), .kp_last(kp_last),
        .busy(busy), .done(done)
    );

    // Registered-read SRAM banks
    always @(posedge clk) begin
        if (kp1_rd_en) kp1_dout <= mem1[kp1_rd_addr];
        if (kp2_rd_en) kp2_dout <= mem2[kp2_rd_addr];
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic fill_mem();
        for (int a = 0; a < DEPTH; a++) begin
            mem1[a] = 19'($urandom);
            mem2[a] = 19'($urandom);
        end
    endtask

    function automatic longint out_snapshot();
        return longint'({kp_valid, kp_row, kp_col, kp_layer, kp_last, busy, done,
                         kp1_rd_en, kp1_rd_addr, kp2_rd_en, kp2_rd_addr});
    endfunction

    task automatic run_drain(input int idx, input int c1, input int c2, input int mode,
                             input int exp_n, input int restart);
        kp_t exp_q[$];
        kp_t got, want;
        int n1, n2, n, cyc, limit;
        int first_issue, first_valid, last_xfer, done_cycle;
        int xfers, issued, data_bad, stable_bad, max_out, both_en, busy_cycles, read_bad;
        logic done_seen, busy_at_done, prev_stall;
        logic [21:0] snap, prev_snap;
        string tag;

        tag = $sformatf("v%0d", idx);
        n1 = (c1 > DEPTH) ? DEPTH : c1;
        n2 = (c2 > DEPTH) ? DEPTH : c2;
        n  = n1 + n2;
        fill_mem();
        for (int i = 0; i < n; i++) begin
            if (i < n1) begin
                want.row = mem1[i][18:10]; want.col = mem1[i][9:0]; want.layer = 1'b0;
            end else begin
                want.row = mem2[i-n1][18:10]; want.col = mem2[i-n1][9:0]; want.layer = 1'b1;
            end
            want.last = (i == n - 1);
            exp_q.push_back(want);
        end
        for (int a = 0; a < DEPTH; a++) begin
            rdcnt1[a] = 0;
            rdcnt2[a] = 0;
        end

        first_issue = -1; first_valid = -1; last_xfer = -1; done_cycle = -1;
        xfers = 0; issued = 0; data_bad = 0; stable_bad = 0; max_out = 0;
        both_en = 0; busy_cycles = 0; read_bad = 0;
        done_seen = 1'b0; busy_at_done = 1'b1; prev_stall = 1'b0; prev_snap = '0;
        limit = 4 * n + 40;

        @(negedge clk);
        kp1_count = 12'(c1);
        kp2_count = 12'(c2);
        start = 1'b1;
        kp_ready = 1'b1;
        cyc = 0;
        while (!done_seen && cyc < limit) begin
            @(negedge clk);
            start = (cyc == restart);
            if (restart >= 0) begin
                kp1_count = 12'd7;
                kp2_count = 12'd7;
            end
            case (mode)
                0:       kp_ready = 1'b1;
                1:       kp_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: kp_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (kp1_rd_en && kp2_rd_en) both_en++;
            if (kp1_rd_en) begin
                rdcnt1[kp1_rd_addr]++; issued++;
                if (first_issue < 0) first_issue = cyc;
            end
            if (kp2_rd_en) begin
                rdcnt2[kp2_rd_addr]++; issued++;
                if (first_issue < 0) first_issue = cyc;
            end
            snap = {kp_valid, kp_row, kp_col, kp_layer, kp_last};
            if (prev_stall && snap != prev_snap) stable_bad++;
            prev_stall = kp_valid && !kp_ready;
            prev_snap  = snap;
            if (kp_valid && first_valid < 0) first_valid = cyc;
            if (kp_valid && kp_ready) begin
                got = {kp_row, kp_col, kp_layer, kp_last};
                xfers++;
                if (exp_q.size() == 0) data_bad++;
                else begin
                    want = exp_q.pop_front();
                    if (got != want) data_bad++;
                end
                if (kp_last) last_xfer = cyc;
            end
            if (issued - xfers > max_out) max_out = issued - xfers;
            if (busy) busy_cycles++;
            if (done) begin
                done_seen = 1'b1; done_cycle = cyc; busy_at_done = busy;
            end
            cyc++;
        end
        start = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_done_width"}, longint'(done), 0);

        for (int a = 0; a < DEPTH; a++) begin
            if (rdcnt1[a] != ((a < n1) ? 1 : 0)) read_bad++;
            if (rdcnt2[a] != ((a < n2) ? 1 : 0)) read_bad++;
        end

        check({tag, "_done_seen"}, longint'(done_seen), 1);
        check({tag, "_xfers"}, xfers, exp_n);
        check({tag, "_stream_mismatches"}, data_bad + exp_q.size(), 0);
        check({tag, "_bad_reads"}, read_bad, 0);
        check({tag, "_dual_rd_en"}, both_en, 0);
        check({tag, "_stall_changes"}, stable_bad, 0);
        total++;
        if (max_out > FDEPTH) begin
            bad++;
            $display("FAIL %s_outstanding: got %0d want <= %0d", tag, max_out, FDEPTH);
        end
        check({tag, "_done_cycle"}, done_cycle, (n == 0) ? 1 : last_xfer + 2);
        check({tag, "_busy_cycles"}, busy_cycles, (n == 0) ? 1 : last_xfer + 2);
        check({tag, "_busy_at_done"}, longint'(busy_at_done), 0);
        if (n == 0) begin
            check({tag, "_reads_issued"}, issued, 0);
            check({tag, "_first_valid"}, first_valid, -1);
        end else if (mode == 0) begin
            check({tag, "_first_rd_cycle"}, first_issue, 0);
            check({tag, "_first_valid_cycle"}, first_valid, 2);
            check({tag, "_last_xfer_cycle"}, last_xfer, n + 1);
        end
        $display("drain %s c1=%0d c2=%0d mode=%0d xfers=%0d done_cycle=%0d", tag, c1, c2,
                 mode, xfers, done_cycle);
    endtask

    initial begin
        logic [18:0] word;
        int w_cyc, seen;

        vecs[0] = '{c1: 3,    c2: 2, mode: 0, exp_n: 5,    restart: -1};
        vecs[1] = '{c1: 0,    c2: 0, mode: 0, exp_n: 0,    restart: -1};
        vecs[2] = '{c1: 4,    c2: 0, mode: 1, exp_n: 4,    restart: -1};
        vecs[3] = '{c1: 3000, c2: 0, mode: 0, exp_n: 2048, restart: -1};
        vecs[4] = '{c1: 5,    c2: 7, mode: 2, exp_n: 12,   restart: -1};
        vecs[5] = '{c1: 3,    c2: 0, mode: 0, exp_n: 3,    restart: 2};
        vecs[6] = '{c1: 2049, c2: 1, mode: 2, exp_n: 2049, restart: -1};

        fill_mem();
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", out_snapshot(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_drain(i, vecs[i].c1, vecs[i].c2, vecs[i].mode, vecs[i].exp_n, vecs[i].restart);

        // Single bank-2 entry at the field extremes
        fill_mem();
        word = {9'd479, 10'd639};
        mem2[0] = word;
        @(negedge clk);
        kp1_count = 12'd0; kp2_count = 12'd1; start = 1'b1; kp_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("t4_rd_en_pair", longint'({kp1_rd_en, kp2_rd_en}), 1);
        check("t4_rd_addr", longint'(kp2_rd_addr), 0);
        w_cyc = 0;
        while (!kp_valid && w_cyc < 10) begin
            @(negedge clk);
            #1;
            w_cyc++;
        end
        check("t4_valid_cycle", w_cyc, 2);
        check("t4_row", longint'(kp_row), 479);
        check("t4_col", longint'(kp_col), 639);
        check("t4_layer_last", longint'({kp_layer, kp_last}), 3);
        @(negedge clk);
        kp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (done) seen++;
        end
        check("t4_done_pulses", seen, 1);
        $display("single bank-2 entry row=479 col=639 drained");

        // Reset in the middle of a bank-1 drain, then a clean restart
        fill_mem();
        @(negedge clk);
        kp1_count = 12'd10; kp2_count = 12'd0; start = 1'b1; kp_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("abort_mid_rd1", longint'({kp1_rd_en, kp_valid, busy}), 7);
        rst_n = 1'b0;
        #1;
        check("abort_rst_outputs", out_snapshot(), 0);
        @(negedge clk);
        #1;
        check("abort_rst_hold", out_snapshot(), 0);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (done || busy || kp_valid || kp1_rd_en) seen++;
        end
        check("abort_quiet_after", seen, 0);
        $display("mid-drain reset aborted, restarting");
        run_drain(100, 2, 0, 0, 2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
